ballot_session_ctrl: RTL and testbench
======================================

Name: ballot_session_ctrl

Overview:
- Sequences the voting datapath: authorises exactly one vote per issued ballot and gates per-candidate vote_valid pulses into one-hot grant pulses for the vote logger.
- Sits between the per-button debouncers and the vote logger; the polling official drives election_open and issue_ballot.
- Handles ballot timeout, multi-press collisions, unauthorised presses and session statistics.

Parameters:
- NUM_CAND, 4, number of candidate vote_valid inputs and grant outputs (2..8).
- TIMEOUT_CYCLES, 1000, cycles an issued ballot stays armed before expiring (>=2).
- COOLDOWN_CYCLES, 10, cycles after a granted vote before the next ballot may be issued (>=1).
- CNT_W, 8, width of the statistics counters.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- election_open  in  1  level; 1 = polling open, 0 = closed/results.
- issue_ballot  in  1  single-cycle pulse from the official arming one vote.
- vote_valid  in  NUM_CAND  debounced single-cycle candidate press pulses.
- grant  out  NUM_CAND  registered one-hot single-cycle vote to the logger.
- ballot_active  out  1  high while in ARMED (voter LED).
- ready  out  1  high in IDLE (official may issue a ballot).
- collision  out  1  single-cycle pulse: more than one vote_valid bit seen in ARMED.
- unauth_press  out  1  single-cycle pulse: any vote_valid outside ARMED.
- ballots_issued  out  CNT_W  accepted issue_ballot count.
- votes_cast  out  CNT_W  grants issued.
- ballots_expired  out  CNT_W  ballots timed out or voided.

Behaviour:
- Reset: state CLOSED; grant=0, ballot_active=0, ready=0, collision=0, unauth_press=0, all counters 0, timer 0. Reset mid-ARMED discards the ballot and does not count it.
- States: CLOSED, IDLE, ARMED, COOLDOWN.
- CLOSED: go to IDLE when election_open=1. issue_ballot is ignored.
- IDLE: if election_open=0, go to CLOSED. Otherwise, on issue_ballot go to ARMED, ballots_issued+1, clear the timer.
- ARMED, priority order:
  1. election_open=0: go to CLOSED, ballots_expired+1, no grant.
  2. Exactly one vote_valid bit set: grant=that bit on the next cycle, votes_cast+1, go to COOLDOWN.
  3. More than one bit set: collision pulse on the next cycle, no grant, stay ARMED, timer keeps running.
  4. Timer == TIMEOUT_CYCLES-1 with no press: go to IDLE, ballots_expired+1.
  - A press arriving in the same cycle as the timeout wins (grant).
  - issue_ballot in ARMED is ignored and not counted.
- COOLDOWN: count COOLDOWN_CYCLES cycles, then go to IDLE, or to CLOSED if election_open=0. issue_ballot during COOLDOWN is ignored.
- Latency: grant, collision and unauth_press are registered, one cycle after the sampled input. grant is never multi-hot and never asserted outside the cycle after an ARMED accept.
- unauth_press: asserted one cycle after any nonzero vote_valid in CLOSED, IDLE or COOLDOWN.
- Counters saturate at 2^CNT_W-1 and do not wrap. They keep their values through CLOSED and clear only on reset.
- Invariant: ballots_issued = votes_cast + ballots_expired + (ballot_active ? 1 : 0), until any counter saturates.
- ready and ballot_active are decoded from the state register (registered outputs).

Optional Feature:
- Macro: BALLOT_PRIORITY_RESOLVE_EN.
- Defined: a multi-bit vote_valid in ARMED grants the lowest-index set bit, pulses collision in the same cycle as the grant, increments votes_cast and goes to COOLDOWN.
- Undefined: multi-bit presses are rejected as described in Behaviour, with no grant and the state staying ARMED.

Test Plan:
All directed tests use TIMEOUT_CYCLES=20, COOLDOWN_CYCLES=4.
1. Reset, election_open=1, issue_ballot pulse, vote_valid=4'b0100 three cycles later -> grant=4'b0100 for exactly one cycle; votes_cast=1, ballots_issued=1; ready returns 4 cycles after the grant.
2. Issue a ballot, no press for 20 cycles -> back to IDLE; ballots_expired=1, votes_cast=0, no grant.
3. In ARMED, vote_valid=4'b0011 -> collision pulse, grant=0, still ARMED; then vote_valid=4'b0010 -> grant=4'b0010. With the macro defined, 4'b0011 -> grant=4'b0001 together with collision.
4. vote_valid=4'b1000 in IDLE and again during COOLDOWN -> unauth_press each time; grant=0, counters unchanged; issue_ballot during COOLDOWN is not counted.
5. Drop election_open while ARMED -> CLOSED; ballots_expired+1; a later press gives unauth_press only.
6. CNT_W=2, run 5 ballot+vote cycles -> votes_cast and ballots_issued saturate at 3. Assert reset mid-ARMED -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/ballot_session_if.sv
// Handshake bundle between the polling official / button debouncers and the
// ballot session controller. The master side drives the controls, the slave side answers.
interface ballot_session_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8
);
  logic                election_open;
  logic                issue_ballot;
  logic [NUM_CAND-1:0] vote_valid;
  logic [NUM_CAND-1:0] grant;
  logic                ballot_active;
  logic                ready;
  logic                collision;
  logic                unauth_press;
  logic [CNT_W-1:0]    ballots_issued;
  logic [CNT_W-1:0]    votes_cast;
  logic [CNT_W-1:0]    ballots_expired;

  modport master (
    output election_open, issue_ballot, vote_valid,
    input  grant, ballot_active, ready, collision, unauth_press,
           ballots_issued, votes_cast, ballots_expired
  );

  modport slave (
    input  election_open, issue_ballot, vote_valid,
    output grant, ballot_active, ready, collision, unauth_press,
           ballots_issued, votes_cast, ballots_expired
  );
endinterface

// File: rtl/ballot_session_ctrl.sv
// Ballot session sequencer: arms one vote per issued ballot and turns a single
// candidate press into a one-hot grant. Build option: BALLOT_PRIORITY_RESOLVE_EN.
module ballot_session_ctrl #(
  parameter int NUM_CAND        = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int COOLDOWN_CYCLES = 10,
  parameter int CNT_W           = 8
) (
  input  logic            clock,
  input  logic            reset,
  ballot_session_if.slave bus
);
  localparam int MAXC = (TIMEOUT_CYCLES > COOLDOWN_CYCLES) ? TIMEOUT_CYCLES : COOLDOWN_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] CD_LAST = TW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {CLOSED, IDLE, ARMED, COOLDOWN} state_t;

  state_t              state_q;
  logic [TW-1:0]       timer_q;
  logic [NUM_CAND-1:0] grant_q;
  logic                coll_q, unauth_q;
  logic [CNT_W-1:0]    issued_q, votes_q, expired_q;

  logic [NUM_CAND-1:0] vv;
  logic                any_press, one_hot, multi;

  assign vv        = bus.vote_valid;
  assign any_press = |vv;
  assign one_hot   = any_press && ((vv & (vv - NUM_CAND'(1))) == '0);
  assign multi     = any_press && !one_hot;

`ifdef BALLOT_PRIORITY_RESOLVE_EN
  logic [NUM_CAND-1:0] lowest;
  assign lowest = vv & (~vv + NUM_CAND'(1));
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLOSED;
      timer_q   <= '0;
      grant_q   <= '0;
      coll_q    <= 1'b0;
      unauth_q  <= 1'b0;
      issued_q  <= '0;
      votes_q   <= '0;
      expired_q <= '0;
    end else begin
      grant_q  <= '0;
      coll_q   <= 1'b0;
      unauth_q <= 1'b0;
      case (state_q)
        CLOSED: begin
          unauth_q <= any_press;
          if (bus.election_open) state_q <= IDLE;
        end
        IDLE: begin
          unauth_q <= any_press;
          if (!bus.election_open) begin
            state_q <= CLOSED;
          end else if (bus.issue_ballot) begin
            state_q  <= ARMED;
            timer_q  <= '0;
            issued_q <= sat_inc(issued_q);
          end
        end
        ARMED: begin
          if (!bus.election_open) begin
            state_q   <= CLOSED;
            expired_q <= sat_inc(expired_q);
          end else if (one_hot) begin
            grant_q <= vv;
            votes_q <= sat_inc(votes_q);
            state_q <= COOLDOWN;
            timer_q <= '0;
          end else if (multi) begin
`ifdef BALLOT_PRIORITY_RESOLVE_EN
            grant_q <= lowest;
            coll_q  <= 1'b1;
            votes_q <= sat_inc(votes_q);
            state_q <= COOLDOWN;
            timer_q <= '0;
`else
            // Timer keeps running; >= below lets a collision on the last
            // armed cycle still expire on the following one.
            coll_q  <= 1'b1;
            timer_q <= timer_q + TW'(1);
`endif
          end else if (timer_q >= TO_LAST) begin
            state_q   <= IDLE;
            expired_q <= sat_inc(expired_q);
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        COOLDOWN: begin
          unauth_q <= any_press;
          if (timer_q >= CD_LAST) begin
            state_q <= bus.election_open ? IDLE : CLOSED;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= CLOSED;
      endcase
    end
  end

  assign bus.grant           = grant_q;
  assign bus.collision       = coll_q;
  assign bus.unauth_press    = unauth_q;
  assign bus.ready           = (state_q == IDLE);
  assign bus.ballot_active   = (state_q == ARMED);
  assign bus.ballots_issued  = issued_q;
  assign bus.votes_cast      = votes_q;
  assign bus.ballots_expired = expired_q;
endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Directed bench for ballot_session_ctrl: main instance with 8-bit counters,
// second instance with 2-bit counters for saturation.
module tb_ballot_session_ctrl;
  logic clock = 1'b0;
  logic reset;
  int   npass = 0;
  int   ntotal = 0;

  always #5 clock = ~clock;

  ballot_session_if #(.NUM_CAND(4), .CNT_W(8)) mif ();
  ballot_session_if #(.NUM_CAND(4), .CNT_W(2)) sif ();

  ballot_session_ctrl #(.NUM_CAND(4), .TIMEOUT_CYCLES(20), .COOLDOWN_CYCLES(4), .CNT_W(8))
    u_dut (.clock(clock), .reset(reset), .bus(mif.slave));
  ballot_session_ctrl #(.NUM_CAND(4), .TIMEOUT_CYCLES(20), .COOLDOWN_CYCLES(4), .CNT_W(2))
    u_sat (.clock(clock), .reset(reset), .bus(sif.slave));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [3:0] gacc;

  initial begin
    reset = 1'b1;
    mif.election_open = 0; mif.issue_ballot = 0; mif.vote_valid = '0;
    sif.election_open = 0; sif.issue_ballot = 0; sif.vote_valid = '0;
    step(); step();
    chk("rst_grant", mif.grant, 0);
    chk("rst_ready", mif.ready, 0);
    chk("rst_active", mif.ballot_active, 0);
    chk("rst_coll", mif.collision, 0);
    chk("rst_unauth", mif.unauth_press, 0);
    chk("rst_issued", mif.ballots_issued, 0);
    chk("rst_votes", mif.votes_cast, 0);
    chk("rst_expired", mif.ballots_expired, 0);
    reset = 1'b0;

    // issue a ballot, vote three cycles later
    mif.election_open = 1; step();
    chk("t1_ready_idle", mif.ready, 1);
    mif.issue_ballot = 1; step(); mif.issue_ballot = 0;
    chk("t1_active", mif.ballot_active, 1);
    chk("t1_issued", mif.ballots_issued, 1);
    step(); step();
    mif.vote_valid = 4'b0100; step(); mif.vote_valid = '0;
    chk("t1_grant", mif.grant, 4'b0100);
    chk("t1_votes", mif.votes_cast, 1);
    step();
    chk("t1_grant_1cyc", mif.grant, 0);
    chk("t1_ready_cd", mif.ready, 0);
    step(); step();
    chk("t1_ready_g3", mif.ready, 0);
    step();
    chk("t1_ready_g4", mif.ready, 1);

    // ballot timeout after 20 armed cycles
    mif.issue_ballot = 1; step(); mif.issue_ballot = 0;
    gacc = '0;
    for (int i = 0; i < 19; i++) begin step(); gacc |= mif.grant; end
    chk("t2_still_armed", mif.ballot_active, 1);
    step(); gacc |= mif.grant;
    chk("t2_idle", mif.ready, 1);
    chk("t2_expired", mif.ballots_expired, 1);
    chk("t2_votes", mif.votes_cast, 1);
    chk("t2_no_grant", gacc, 0);

    // multi-press collision
    mif.issue_ballot = 1; step(); mif.issue_ballot = 0;
    chk("t3_issued", mif.ballots_issued, 3);
    mif.vote_valid = 4'b0011; step(); mif.vote_valid = '0;
    chk("t3_coll", mif.collision, 1);
`ifdef BALLOT_PRIORITY_RESOLVE_EN
    chk("t3_grant_low", mif.grant, 4'b0001);
    chk("t3_votes", mif.votes_cast, 2);
    chk("t3_cooldown", mif.ballot_active, 0);
`else
    chk("t3_grant_none", mif.grant, 0);
    chk("t3_still_armed", mif.ballot_active, 1);
    mif.vote_valid = 4'b0010; step(); mif.vote_valid = '0;
    chk("t3_grant", mif.grant, 4'b0010);
    chk("t3_coll_clr", mif.collision, 0);
    chk("t3_votes", mif.votes_cast, 2);
`endif
    step(); step(); step(); step();
    chk("t3_ready", mif.ready, 1);

    // unauthorised presses in IDLE and COOLDOWN
    mif.vote_valid = 4'b1000; step(); mif.vote_valid = '0;
    chk("t4_unauth_idle", mif.unauth_press, 1);
    chk("t4_grant_idle", mif.grant, 0);
    chk("t4_votes_idle", mif.votes_cast, 2);
    chk("t4_issued_idle", mif.ballots_issued, 3);
    mif.issue_ballot = 1; step(); mif.issue_ballot = 0;
    mif.vote_valid = 4'b0001; step(); mif.vote_valid = '0;
    chk("t4_grant", mif.grant, 4'b0001);
    mif.vote_valid = 4'b1000; step(); mif.vote_valid = '0;
    chk("t4_unauth_cd", mif.unauth_press, 1);
    chk("t4_grant_cd", mif.grant, 0);
    mif.issue_ballot = 1; step(); mif.issue_ballot = 0;
    chk("t4_issue_cd_ignored", mif.ballots_issued, 4);
    step(); step();
    chk("t4_ready", mif.ready, 1);
    chk("t4_votes", mif.votes_cast, 3);
    chk("t4_expired", mif.ballots_expired, 1);

    // election closes while armed
    mif.issue_ballot = 1; step(); mif.issue_ballot = 0;
    mif.election_open = 0; step();
    chk("t5_expired", mif.ballots_expired, 2);
    chk("t5_active", mif.ballot_active, 0);
    chk("t5_ready", mif.ready, 0);
    mif.vote_valid = 4'b0100; step(); mif.vote_valid = '0;
    chk("t5_unauth", mif.unauth_press, 1);
    chk("t5_grant", mif.grant, 0);
    chk("t5_votes", mif.votes_cast, 3);
    mif.issue_ballot = 1; step(); mif.issue_ballot = 0;
    chk("t5_issue_closed", mif.ballots_issued, 5);

    // press on the last armed cycle beats the timeout
    mif.election_open = 1; step();
    mif.issue_ballot = 1; step(); mif.issue_ballot = 0;
    for (int i = 0; i < 19; i++) step();
    mif.vote_valid = 4'b0100; step(); mif.vote_valid = '0;
    chk("t7_tie_grant", mif.grant, 4'b0100);
    chk("t7_tie_votes", mif.votes_cast, 4);
    chk("t7_tie_expired", mif.ballots_expired, 2);

    // saturation with 2-bit counters, then reset mid-ARMED
    sif.election_open = 1; step();
    for (int i = 0; i < 5; i++) begin
      sif.issue_ballot = 1; step(); sif.issue_ballot = 0;
      sif.vote_valid = 4'b0001; step(); sif.vote_valid = '0;
      step(); step(); step(); step();
    end
    chk("t6_issued_sat", sif.ballots_issued, 3);
    chk("t6_votes_sat", sif.votes_cast, 3);
    chk("t6_expired", sif.ballots_expired, 0);
    sif.issue_ballot = 1; step(); sif.issue_ballot = 0;
    chk("t6_armed", sif.ballot_active, 1);
    reset = 1'b1; step();
    chk("t6_rst_active", sif.ballot_active, 0);
    chk("t6_rst_ready", sif.ready, 0);
    chk("t6_rst_issued", sif.ballots_issued, 0);
    chk("t6_rst_votes", sif.votes_cast, 0);
    chk("t6_rst_expired", sif.ballots_expired, 0);
    chk("t6_rst_grant", sif.grant, 0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
